// File: rtl/pe_row_pkg.sv
// Shared definitions for the PE row accumulator: FSM states, operand-select
// modes and the saturating add used by every PE.
package pe_row_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SYS   = 2'd0;
  localparam logic [1:0] MODE_CAST  = 2'd1;
  localparam logic [1:0] MODE_BCAST = 2'd2;

  // Wide enough that an AW-bit accumulator plus a 2*DW-bit product never
  // overflows before the clamp (AW up to 62).
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      aw
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (aw - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/pe_row_acc_mac.sv
// Single processing element: forwards its selected operand to the next row
// and accumulates operand*weight with saturation.
module pe_mac_sat
  import pe_row_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beat,
  input  logic                 zero,
  input  logic signed [DW-1:0] operand,
  input  logic signed [DW-1:0] weight,
  output logic signed [DW-1:0] next_pixel,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod_p0;
  logic signed [AW-1:0]   acc_p1;
  logic signed [DW-1:0]   opnd_p1;

  assign prod_p0 = operand * weight;

  // p0 -> p1: product folded into the accumulator, operand registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p1  <= '0;
      opnd_p1 <= '0;
    end else begin
      if (zero)
        acc_p1 <= '0;
      else if (beat)
        acc_p1 <= AW'(sat_add({{(SAT_W-AW){acc_p1[AW-1]}}, acc_p1},
                              {{(SAT_W-2*DW){prod_p0[2*DW-1]}}, prod_p0},
                              AW));
      if (beat)
        opnd_p1 <= operand;
    end
  end

  assign acc        = acc_p1;
  assign next_pixel = opnd_p1;

endmodule

// File: rtl/pe_row_acc.sv
// Row of NUM_PE multiply-accumulate PEs sharing one run controller: counts
// beats, then holds the partial sums until the consumer takes them.
module pe_row_acc
  import pe_row_pkg::*;
#(
  parameter int NUM_PE   = 16,
  parameter int DW       = 8,
  parameter int AW       = 24,
  parameter int NUM_CAST = 3,
  parameter int LW       = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     mode,
  input  logic [LW-1:0]                  acc_len,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_PE-1:0][DW-1:0]      pixel,
  input  logic [NUM_CAST-1:0][DW-1:0]    pixel_cast,
  input  logic [NUM_PE-1:0][DW-1:0]      weight,
  output logic [NUM_PE-1:0][DW-1:0]      next_pixel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_PE-1:0][AW-1:0]      psum,
  output logic                           busy
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACC   = ST_ACC;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  logic [1:0]    state;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len_q;
  logic [1:0]    mode_q;

  logic          accept;
  logic          last;
  logic          zero_acc;
  logic [1:0]    mode_eff;
  logic [LW-1:0] len_eff;
  logic [LW:0]   target;
  logic [LW:0]   cnt_nxt;

  assign in_ready  = ((state == S_IDLE) || (state == S_ACC)) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);
  assign zero_acc  = clear || (out_valid && out_ready);

  // The first beat of a run is steered by the live inputs, later beats by the latched copies.
  assign mode_eff = (state == S_IDLE) ? mode    : mode_q;
  assign len_eff  = (state == S_IDLE) ? acc_len : len_q;
  assign target   = (len_eff == '0) ? (LW+1)'(1) : {1'b0, len_eff};
  assign cnt_nxt  = (state == S_IDLE) ? (LW+1)'(1) : ({1'b0, cnt} + (LW+1)'(1));
  assign last     = accept && (cnt_nxt == target);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      len_q  <= '0;
      mode_q <= '0;
    end else if (clear) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mode_q <= mode;
            len_q  <= acc_len;
            cnt    <= cnt_nxt[LW-1:0];
            state  <= last ? S_DRAIN : S_ACC;
          end
        end
        S_ACC: begin
          if (accept) begin
            cnt <= cnt_nxt[LW-1:0];
            if (last)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_PE; i++) begin : g_pe
    logic [DW-1:0] cast_i;
    logic [DW-1:0] operand_i;

    if (i < NUM_CAST) begin : g_cast
      assign cast_i = pixel_cast[i];
    end else begin : g_nocast
      assign cast_i = pixel[i];
    end

    always_comb begin
      operand_i = pixel[i];
      case (mode_eff)
        MODE_CAST:  operand_i = cast_i;
        MODE_BCAST: operand_i = pixel_cast[0];
        default:    operand_i = pixel[i];
      endcase
    end

    pe_mac_sat #(
      .DW (DW),
      .AW (AW)
    ) u_pe (
      .clk        (clk),
      .rst        (rst),
      .beat       (accept),
      .zero       (zero_acc),
      .operand    ($signed(operand_i)),
      .weight     ($signed(weight[i])),
      .next_pixel (next_pixel[i]),
      .acc        (psum[i])
    );
  end

endmodule
